// File: rtl/io_bank_ctrl.sv
// Controller for a bank of bidirectional IO cells: per-pad cell configuration
// registers, registered output path, and synchronised/filtered input path with edge flags.
module io_bank_ctrl #(
  parameter int                      NUM_PADS     = 8,
  parameter int                      IOCELL_CFG_W = 3,
  parameter logic [IOCELL_CFG_W-1:0] CFG_RST      = '1,
  parameter int                      SYNC_STAGES  = 2,
  parameter int                      FILT_LEN     = 4,
  parameter int                      ADDR_W       = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             reg_req,
  input  logic                             reg_we,
  input  logic [ADDR_W-1:0]                reg_addr,
  input  logic [31:0]                      reg_wdata,
  output logic                             reg_gnt,
  output logic                             reg_rvalid,
  output logic [31:0]                      reg_rdata,
  input  logic [NUM_PADS-1:0]              core_out,
  output logic [NUM_PADS-1:0]              core_in,
  output logic                             irq,
  output logic [NUM_PADS*IOCELL_CFG_W-1:0] cell_cfg,
  output logic [NUM_PADS-1:0]              cell_from_core,
  input  logic [NUM_PADS-1:0]              cell_to_core
);

  localparam int W     = IOCELL_CFG_W;
  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(FILT_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(NUM_PADS);
  localparam logic [ADDR_W-1:0] ADDR_PADIN  = ADDR_W'(NUM_PADS + 1);

  logic [W-1:0]        cfg_q   [NUM_PADS];
  logic [NUM_PADS-1:0] filt_en;
  logic [NUM_PADS-1:0] irq_en;
  logic [NUM_PADS-1:0] status;
  logic [NUM_PADS-1:0] core_in_p2;
  logic [NUM_PADS-1:0] sync_p1 [SYNC_STAGES];
  logic [CNT_W-1:0]    cnt_q   [NUM_PADS];

  logic [NUM_PADS-1:0] pad_we;
  logic [NUM_PADS-1:0] status_w1c;
  logic [NUM_PADS-1:0] core_in_nxt;
  logic [CNT_W-1:0]    cnt_nxt [NUM_PADS];
  logic [NUM_PADS-1:0] s;
  logic [31:0]         rd_data_p0;
  logic                unused_wdata;

  assign reg_gnt      = reg_req;
  assign core_in      = core_in_p2;
  assign s            = sync_p1[SYNC_STAGES-1];
  assign unused_wdata = ^reg_wdata;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_cfg_bus
    assign cell_cfg[g*W +: W] = cfg_q[g];
  end

  // Bus decode and read mux (combinational, registered into the response below)
  always_comb begin
    pad_we     = '0;
    status_w1c = '0;
    rd_data_p0 = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_we[i] = reg_req && reg_we && (reg_addr == ADDR_W'(i));
      if (reg_addr == ADDR_W'(i))
        rd_data_p0[W+1:0] = {irq_en[i], filt_en[i], cfg_q[i]};
    end
    if (reg_req && reg_we && (reg_addr == ADDR_STATUS))
      status_w1c = reg_wdata[NUM_PADS-1:0];
    if (reg_addr == ADDR_STATUS)
      rd_data_p0[NUM_PADS-1:0] = status;
    else if (reg_addr == ADDR_PADIN)
      rd_data_p0[NUM_PADS-1:0] = core_in_p2;
  end

  // Input conditioning: a filt_en change freezes core_in and restarts the filter
  always_comb begin
    core_in_nxt = core_in_p2;
    for (int i = 0; i < NUM_PADS; i++) begin
      cnt_nxt[i] = '0;
      if (pad_we[i] && (reg_wdata[W] != filt_en[i])) begin
        cnt_nxt[i] = '0;
      end else if (!filt_en[i]) begin
        core_in_nxt[i] = s[i];
      end else if (s[i] != core_in_p2[i]) begin
        if (cnt_q[i] == CNT_MAX)
          core_in_nxt[i] = s[i];
        else
          cnt_nxt[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Stage p1: synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p1[k] <= '0;
    end else begin
      sync_p1[0] <= cell_to_core;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p1[k] <= sync_p1[k-1];
    end
  end

  // Stage p2: conditioned input, edge flags, interrupt, config and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        cfg_q[i] <= CFG_RST;
        cnt_q[i] <= '0;
      end
      filt_en        <= '0;
      irq_en         <= '0;
      status         <= '0;
      core_in_p2     <= '0;
      irq            <= 1'b0;
      reg_rvalid     <= 1'b0;
      reg_rdata      <= '0;
      cell_from_core <= '0;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        cnt_q[i] <= cnt_nxt[i];
        if (pad_we[i]) begin
          cfg_q[i]   <= reg_wdata[W-1:0];
          filt_en[i] <= reg_wdata[W];
          irq_en[i]  <= reg_wdata[W+1];
        end
      end
      core_in_p2     <= core_in_nxt;
      status         <= (status & ~status_w1c) | (core_in_nxt & ~core_in_p2);
      irq            <= |(status & irq_en);
      reg_rvalid     <= reg_req;
      reg_rdata      <= (reg_req && !reg_we) ? rd_data_p0 : '0;
      cell_from_core <= core_out;
    end
  end

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Bench for io_bank_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural bank model.
module tb_io_bank_ctrl;
  localparam int NP = 8;
  localparam int W  = 3;
  localparam int SS = 2;
  localparam int FL = 4;
  localparam int AW = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reg_req = 1'b0, reg_we = 1'b0;
  logic [AW-1:0]     reg_addr = '0;
  logic [31:0]       reg_wdata = '0;
  logic              reg_gnt, reg_rvalid, irq;
  logic [31:0]       reg_rdata;
  logic [NP-1:0]     core_out = '0, core_in, cell_from_core;
  logic [NP-1:0]     cell_to_core = '0;
  logic [NP*W-1:0]   cell_cfg;

  io_bank_ctrl #(.NUM_PADS(NP), .IOCELL_CFG_W(W), .CFG_RST('1), .SYNC_STAGES(SS),
                 .FILT_LEN(FL), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_gnt(reg_gnt), .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata),
    .core_out(core_out), .core_in(core_in), .irq(irq), .cell_cfg(cell_cfg),
    .cell_from_core(cell_from_core), .cell_to_core(cell_to_core));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [W-1:0]  m_cfg [NP];
  logic [NP-1:0] m_fe, m_ie, m_st, m_cin, m_cfo;
  logic [NP-1:0] m_hist [$];
  int            m_run [NP];
  logic          m_rvalid, m_irq;
  logic [31:0]   m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NP; i++) begin
      m_cfg[i] = '1;
      m_run[i] = 0;
    end
    m_fe = '0; m_ie = '0; m_st = '0; m_cin = '0; m_cfo = '0;
    m_rvalid = 1'b0; m_irq = 1'b0; m_rdata = '0;
    m_hist = {};
    repeat (SS) m_hist.push_back('0);
  endtask

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a < NP)          r[W+1:0] = {m_ie[a], m_fe[a], m_cfg[a]};
    else if (a == NP)    r[NP-1:0] = m_st;
    else if (a == NP+1)  r[NP-1:0] = m_cin;
    return r;
  endfunction

  function automatic logic [NP*W-1:0] m_cfg_bus();
    logic [NP*W-1:0] p;
    for (int i = 0; i < NP; i++) p[i*W +: W] = m_cfg[i];
    return p;
  endfunction

  // Advance the model across the coming clock edge using the inputs now applied
  task automatic m_step();
    logic [NP-1:0] s, n_cin, w1c;
    int a;
    bit wr;
    if (!rst_n) begin
      m_reset();
      return;
    end
    a = int'(reg_addr);
    s = m_hist[SS-1];
    n_cin = m_cin;
    for (int i = 0; i < NP; i++) begin
      wr = reg_req && reg_we && (a == i);
      if (wr && (reg_wdata[W] != m_fe[i])) m_run[i] = 0;
      else if (!m_fe[i]) begin
        n_cin[i] = s[i];
        m_run[i] = 0;
      end else if (s[i] != m_cin[i]) begin
        m_run[i]++;
        if (m_run[i] >= FL) begin
          n_cin[i] = s[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
    end
    w1c = (reg_req && reg_we && a == NP) ? reg_wdata[NP-1:0] : '0;
    m_rdata  = (reg_req && !reg_we) ? m_read(a) : 32'h0;
    m_rvalid = reg_req;
    m_irq    = |(m_st & m_ie);
    m_st     = (m_st & ~w1c) | (n_cin & ~m_cin);
    for (int i = 0; i < NP; i++)
      if (reg_req && reg_we && a == i) begin
        m_cfg[i] = reg_wdata[W-1:0];
        m_fe[i]  = reg_wdata[W];
        m_ie[i]  = reg_wdata[W+1];
      end
    m_cin = n_cin;
    m_cfo = core_out;
    m_hist.push_front(cell_to_core);
    void'(m_hist.pop_back());
  endtask

  task automatic check_all();
    chk("core_in", 32'(core_in), 32'(m_cin));
    chk("cell_cfg", 32'(cell_cfg), 32'(m_cfg_bus()));
    chk("cell_from_core", 32'(cell_from_core), 32'(m_cfo));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rvalid", 32'(reg_rvalid), 32'(m_rvalid));
    if (m_rvalid) chk("rdata", reg_rdata, m_rdata);
  endtask

  // Inputs are set at the falling edge before calling; returns at the next falling edge
  task automatic cycle();
    #1;
    chk("gnt", 32'(reg_gnt), 32'(reg_req));
    m_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic bus(input logic w, input int a, input logic [31:0] d);
    reg_req = 1'b1; reg_we = w; reg_addr = AW'(a); reg_wdata = d;
  endtask

  task automatic idle();
    reg_req = 1'b0; reg_we = 1'b0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    check_all();
    chk("rst_cell_cfg", 32'(cell_cfg), 32'h00FF_FFFF);
    chk("rst_rdata", reg_rdata, 32'h0);
    rst_n = 1'b1;
    cycle();

    // Pad 3 config write/readback and output path
    bus(1, 3, 32'h0); cycle();
    chk("t2_wr_rvalid", 32'(reg_rvalid), 32'h1);
    chk("t2_cfg3", 32'(cell_cfg[11:9]), 32'h0);
    bus(0, 3, 32'h0); core_out[3] = 1'b1; cycle();
    chk("t2_rd_rvalid", 32'(reg_rvalid), 32'h1);
    chk("t2_rdata", reg_rdata, 32'h0);
    chk("t2_from_core", 32'(cell_from_core[3]), 32'h1);
    idle(); core_out = '0; cycle();
    chk("t2_idle_rvalid", 32'(reg_rvalid), 32'h0);

    // Unfiltered latency on pad 2
    cell_to_core[2] = 1'b1;
    cycle(); chk("t3_lat1", 32'(core_in[2]), 32'h0);
    cycle(); chk("t3_lat2", 32'(core_in[2]), 32'h0);
    cycle(); chk("t3_lat3", 32'(core_in[2]), 32'h1);
    bus(0, NP, 32'h0); cycle();
    chk("t3_status2", 32'(reg_rdata[2]), 32'h1);
    idle();

    // Glitch filter on pad 5
    bus(1, 5, 32'h8); cycle(); idle();
    cell_to_core[5] = 1'b1;
    repeat (3) cycle();
    cell_to_core[5] = 1'b0;
    repeat (8) begin
      cycle();
      chk("t4_short_pulse", 32'(core_in[5]), 32'h0);
    end
    cell_to_core[5] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 5) chk("t4_before", 32'(core_in[5]), 32'h0);
      if (k == 6) chk("t4_after", 32'(core_in[5]), 32'h1);
    end
    cell_to_core[5] = 1'b0;
    repeat (8) cycle();
    bus(0, NP, 32'h0); cycle();
    chk("t4_status5", 32'(reg_rdata[5]), 32'h1);
    idle();

    // Interrupt on pad 1, clear, and clear coinciding with a new edge
    bus(1, 1, 32'h10); cycle(); idle();
    cell_to_core[1] = 1'b1;
    repeat (4) cycle();
    chk("t5_irq_set", 32'(irq), 32'h1);
    bus(1, NP, 32'h2); cycle(); idle();
    cycle();
    chk("t5_irq_clr", 32'(irq), 32'h0);
    cell_to_core[1] = 1'b0;
    repeat (4) cycle();
    cell_to_core[1] = 1'b1;
    cycle(); cycle();
    bus(1, NP, 32'h2); cycle();
    chk("t5_coincident_edge", 32'(core_in[1]), 32'h1);
    bus(0, NP, 32'h0); cycle();
    chk("t5_set_wins", 32'(reg_rdata[1]), 32'h1);
    idle();

    // Unmapped address, back-to-back
    bus(1, NP + 5, 32'hFFFF_FFFF); cycle();
    chk("t6_wr_rvalid", 32'(reg_rvalid), 32'h1);
    bus(0, NP + 5, 32'h0); cycle();
    chk("t6_rd_rvalid", 32'(reg_rvalid), 32'h1);
    chk("t6_rdata", reg_rdata, 32'h0);
    idle(); cycle();

    // Randomized traffic with an asynchronous reset in the middle of a transfer
    for (int n = 0; n < 3000; n++) begin
      reg_req = ($urandom_range(0, 1) == 1);
      reg_we  = ($urandom_range(0, 1) == 1);
      reg_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, NP + 2));
      reg_wdata = $urandom;
      core_out  = NP'($urandom);
      for (int i = 0; i < NP; i++)
        if ($urandom_range(0, 5) == 0) cell_to_core[i] = ~cell_to_core[i];
      if (n == 1500) begin
        reg_req = 1'b1; reg_we = 1'b0; reg_addr = AW'(NP);
        #1;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("t1_rst_cfg", 32'(cell_cfg), 32'h00FF_FFFF);
        chk("t1_rst_core_in", 32'(core_in), 32'h0);
        chk("t1_rst_irq", 32'(irq), 32'h0);
        repeat (3) cycle();
        idle();
        rst_n = 1'b1;
        cycle();
        chk("t1_no_rvalid", 32'(reg_rvalid), 32'h0);
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
